sram_bank_array: RTL and testbench

Parametrised multi-bank, byte-lane SRAM core: the successor to the fixed 2-bank × 4-lane SRAM core behind the AHB SRAM controller. It stores `NUM_BANKS` banks of `LANES` byte-wide memories and steers writes per byte enable. It returns read data through a credit-limited, backpressured response path. After every reset, a built-in zero-fill sequencer initialises all memories before requests are accepted.

---
 rtl/sram_bank_array_pkg.sv | 24 ++
 rtl/sram_lane_mem.sv | 31 +++
 rtl/sram_bank_array.sv | 196 +++++++++++++++++++
 tb/tb_sram_bank_array.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/sram_bank_array_pkg.sv
// Shared definitions for the sram_bank_array core: the sequencer state
// encoding, the response FIFO depth and the lane memory width.
// The optional parity feature is selected with SRAM_BANK_ARRAY_PARITY_EN.
package sram_bank_array_pkg;

    // INIT zero-fills every lane memory, RUN serves requests
    typedef enum logic [0:0] {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    // Response FIFO depth; also the total number of read credits
    localparam int FIFO_DEPTH = 2;

    // Width of one lane memory word: a byte, plus a parity bit when enabled
    function automatic int lane_width();
`ifdef SRAM_BANK_ARRAY_PARITY_EN
        return 9;
`else
        return 8;
`endif
    endfunction

endpackage

// File: rtl/sram_lane_mem.sv
// Single-port synchronous RAM used as one byte lane of one bank.
// Write when we is high; the word at addr is registered onto rdata every
// cycle. Width is 8, or 9 with SRAM_BANK_ARRAY_PARITY_EN (set by the parent).
module sram_lane_mem
    import sram_bank_array_pkg::*;
#(
    parameter int WIDTH  = lane_width(),
    parameter int ADDR_W = 13
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [WIDTH-1:0]  wdata,
    output logic [WIDTH-1:0]  rdata
);

    logic [WIDTH-1:0] mem [2**ADDR_W];

    // Synchronous write plus registered read of the addressed word
    // NOTE: the array has no reset branch so it maps onto SRAM macros; the
    // parent's zero-fill sequencer gives it a defined state instead.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments keep every register updating from
        // pre-edge values, independent of statement order.
        if (we) begin
            mem[addr] <= wdata;
        end
        rdata <= mem[addr];
    end

endmodule

// File: rtl/sram_bank_array.sv
// sram_bank_array: NUM_BANKS banks of LANES byte-wide memories with per-byte
// write enables, a zero-fill sequencer run after every reset, and a read
// response path limited to FIFO_DEPTH outstanding reads.
// Define SRAM_BANK_ARRAY_PARITY_EN for 9-bit lanes with even parity checking.
module sram_bank_array
    import sram_bank_array_pkg::*;
#(
    parameter int  NUM_BANKS = 2,
    parameter int  LANES     = 4,
    parameter int  ADDR_W    = 13,
    localparam int DW        = 8 * LANES,
    localparam int BANK_W    = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1
) (
    input  logic              hclk,
    input  logic              hreset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [BANK_W-1:0] req_bank,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [LANES-1:0]  req_be,
    input  logic [DW-1:0]     req_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DW-1:0]     rsp_rdata,
    output logic              rsp_err,
    output logic              init_done
);

    localparam int              LW         = lane_width();
    localparam logic [BANK_W:0] BANK_LIMIT = (BANK_W + 1)'(NUM_BANKS);

    typedef struct packed {
        logic          err;
        logic [DW-1:0] data;
    } rsp_t;

    state_t            state;
    logic [ADDR_W-1:0] init_addr;
    logic              init_active;
    logic [ADDR_W-1:0] mem_addr;

    logic              accept;
    logic              wr_accept;
    logic              rd_accept;
    logic              bank_ok;
    logic [1:0]        outstanding;
    logic              credit_ok;

    logic              s0_valid;
    logic              s0_bad;
    logic [BANK_W-1:0] s0_bank;
    logic              s1_valid;
    rsp_t              s1_rsp;
    rsp_t              sel_rsp;

    logic [1:0]        fifo_count;
    rsp_t              fifo_head;
    rsp_t              fifo_tail;
    logic              push;
    logic              pop;

    logic [LW-1:0]     lane_rd [NUM_BANKS][LANES];

    // Zero-fill sequencer: one address per cycle across all lanes, then RUN
    always_ff @(posedge hclk) begin
        if (hreset) begin
            state     <= ST_INIT;
            init_addr <= '0;
        end else if (state == ST_INIT) begin
            init_addr <= init_addr + ADDR_W'(1);
            if (init_addr == '1) begin
                state <= ST_RUN;
            end
        end
    end

    assign init_active = (state == ST_INIT);
    assign init_done   = (state == ST_RUN);
    assign mem_addr    = init_active ? init_addr : req_addr;

    // Every accepted-but-unpopped read holds one credit until its pop edge.
    // Writes never produce a response, so they bypass the credit check.
    assign outstanding = fifo_count + {1'b0, s0_valid} + {1'b0, s1_valid};
    assign credit_ok   = (outstanding < 2'(FIFO_DEPTH));
    assign req_ready   = (state == ST_RUN) && (credit_ok || req_write);
    assign accept      = req_valid && req_ready;
    assign wr_accept   = accept && req_write;
    assign rd_accept   = accept && !req_write;
    assign bank_ok     = ({1'b0, req_bank} < BANK_LIMIT);

    for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
        for (genvar l = 0; l < LANES; l++) begin : g_lane
            logic          we;
            logic [7:0]    byte_in;
            logic [LW-1:0] wdata;

            assign byte_in = init_active ? 8'h00 : req_wdata[8*l +: 8];
            assign we      = init_active
                          || (wr_accept && req_be[l] && (req_bank == BANK_W'(b)));
`ifdef SRAM_BANK_ARRAY_PARITY_EN
            assign wdata   = {^byte_in, byte_in};
`else
            assign wdata   = byte_in;
`endif

            sram_lane_mem #(
                .WIDTH  (LW),
                .ADDR_W (ADDR_W)
            ) u_mem (
                .clk   (hclk),
                .we    (we),
                .addr  (mem_addr),
                .wdata (wdata),
                .rdata (lane_rd[b][l])
            );
        end
    end

    // Gather the addressed bank's lanes into one word and flag its errors
    always_comb begin
        // NOTE: assigning a default before any conditional path keeps this
        // block purely combinational; a missed path would otherwise latch.
        sel_rsp = '0;
        for (int b = 0; b < NUM_BANKS; b++) begin
            if (s0_bank == BANK_W'(b)) begin
                for (int l = 0; l < LANES; l++) begin
                    sel_rsp.data[8*l +: 8] = lane_rd[b][l][7:0];
`ifdef SRAM_BANK_ARRAY_PARITY_EN
                    sel_rsp.err = sel_rsp.err | (^lane_rd[b][l]);
`endif
                end
            end
        end
        sel_rsp.err = sel_rsp.err | s0_bad;
    end

    // Read pipeline: s0 tracks the memory access, s1 registers the lane word
    always_ff @(posedge hclk) begin
        if (hreset) begin
            s0_valid <= 1'b0;
            s0_bad   <= 1'b0;
            s0_bank  <= '0;
            s1_valid <= 1'b0;
            s1_rsp   <= '0;
        end else begin
            s0_valid <= rd_accept;
            s0_bank  <= req_bank;
            s0_bad   <= !bank_ok;
            s1_valid <= s0_valid;
            s1_rsp   <= sel_rsp;
        end
    end

    assign push = s1_valid;
    assign pop  = rsp_valid && rsp_ready;

    // Two-entry response FIFO; the head register drives the response outputs
    always_ff @(posedge hclk) begin
        if (hreset) begin
            fifo_count <= '0;
            fifo_head  <= '0;
            fifo_tail  <= '0;
        end else begin
            case ({push, pop})
                2'b10: begin
                    if (fifo_count == 2'd0) begin
                        fifo_head <= s1_rsp;
                    end else begin
                        fifo_tail <= s1_rsp;
                    end
                    fifo_count <= fifo_count + 2'd1;
                end
                2'b01: begin
                    fifo_head  <= fifo_tail;
                    fifo_count <= fifo_count - 2'd1;
                end
                2'b11: begin
                    if (fifo_count == 2'd1) begin
                        fifo_head <= s1_rsp;
                    end else begin
                        fifo_head <= fifo_tail;
                        fifo_tail <= s1_rsp;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign rsp_valid = (fifo_count != 2'd0);
    assign rsp_rdata = fifo_head.data;
    assign rsp_err   = fifo_head.err;

endmodule

// File: tb/tb_sram_bank_array.sv
// Self-checking bench for sram_bank_array. Three banks are instantiated so
// the 2-bit bank field can carry an out-of-range bank (3). Expected values
// come from a word-level memory model and a queue of pending responses.
// With SRAM_BANK_ARRAY_PARITY_EN defined, a stored parity bit is corrupted.
module tb_sram_bank_array;

    localparam int NUM_BANKS = 3;
    localparam int LANES     = 4;
    localparam int ADDR_W    = 13;
    localparam int DW        = 8 * LANES;
    localparam int BANK_W    = 2;
    localparam int DEPTH     = 2 ** ADDR_W;

    logic              hclk = 1'b0;
    logic              hreset = 1'b1;
    logic              req_valid = 1'b0;
    logic              req_ready;
    logic              req_write = 1'b0;
    logic [BANK_W-1:0] req_bank = '0;
    logic [ADDR_W-1:0] req_addr = '0;
    logic [LANES-1:0]  req_be = '0;
    logic [DW-1:0]     req_wdata = '0;
    logic              rsp_valid;
    logic              rsp_ready = 1'b0;
    logic [DW-1:0]     rsp_rdata;
    logic              rsp_err;
    logic              init_done;

    sram_bank_array #(
        .NUM_BANKS (NUM_BANKS),
        .LANES     (LANES),
        .ADDR_W    (ADDR_W)
    ) dut (
        .hclk      (hclk),
        .hreset    (hreset),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_write (req_write),
        .req_bank  (req_bank),
        .req_addr  (req_addr),
        .req_be    (req_be),
        .req_wdata (req_wdata),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err),
        .init_done (init_done)
    );

    always #5 hclk = ~hclk;

    typedef struct {
        logic [DW-1:0] data;
        logic          err;
        longint        due;
    } exp_rsp_t;

    logic [DW-1:0] mem_model [int];
    bit            corrupt [int];
    exp_rsp_t      rsp_q [$];
    longint        edges = 0;
    bit            run_model = 1'b0;
    int            init_cnt = 0;
    int            checks = 0;
    int            fails = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int key(input int b, input int a);
        return b * DEPTH + a;
    endfunction

    function automatic logic [DW-1:0] model_read(input int b, input int a);
        if (mem_model.exists(key(b, a))) return mem_model[key(b, a)];
        return '0;
    endfunction

    // One clock cycle: drive inputs after a falling edge, check outputs,
    // then advance the model across the rising edge.
    task automatic cycle(input bit v, input bit w, input logic [BANK_W-1:0] b,
                         input logic [ADDR_W-1:0] a, input logic [LANES-1:0] be,
                         input logic [DW-1:0] d, input bit rr);
        bit            exp_ready;
        bit            exp_rv;
        bit            acc;
        bit            do_pop;
        int            bi;
        int            ai;
        logic [DW-1:0] cur;
        exp_rsp_t      e;
        req_valid = v;
        req_write = w;
        req_bank  = b;
        req_addr  = a;
        req_be    = be;
        req_wdata = d;
        rsp_ready = rr;
        #1;
        exp_ready = run_model && ((rsp_q.size() < 2) || w);
        check("req_ready", req_ready, exp_ready);
        check("init_done", init_done, run_model);
        exp_rv = 1'b0;
        if (rsp_q.size() > 0) begin
            if (rsp_q[0].due <= edges) exp_rv = 1'b1;
        end
        check("rsp_valid", rsp_valid, exp_rv);
        if (exp_rv) begin
            check("rsp_rdata", rsp_rdata, rsp_q[0].data);
            check("rsp_err", rsp_err, rsp_q[0].err);
        end
        do_pop = exp_rv && rr;
        acc    = v && exp_ready;
        bi     = int'(b);
        ai     = int'(a);
        @(posedge hclk);
        edges++;
        if (do_pop) void'(rsp_q.pop_front());
        if (acc && w && (bi < NUM_BANKS)) begin
            cur = model_read(bi, ai);
            for (int l = 0; l < LANES; l++) begin
                if (be[l]) cur[8*l +: 8] = d[8*l +: 8];
            end
            mem_model[key(bi, ai)] = cur;
        end else if (acc && !w) begin
            e.data = (bi < NUM_BANKS) ? model_read(bi, ai) : '0;
            e.err  = (bi >= NUM_BANKS) || corrupt.exists(key(bi, ai));
            e.due  = edges + 2;
            rsp_q.push_back(e);
        end
        if (!run_model) begin
            init_cnt++;
            if (init_cnt == DEPTH) run_model = 1'b1;
        end
        @(negedge hclk);
    endtask

    task automatic idle(input int n, input bit rr);
        for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, '0, '0, '0, '0, rr);
    endtask

    task automatic rd(input logic [BANK_W-1:0] b, input logic [ADDR_W-1:0] a, input bit rr);
        cycle(1'b1, 1'b0, b, a, '0, '0, rr);
    endtask

    task automatic wr(input logic [BANK_W-1:0] b, input logic [ADDR_W-1:0] a,
                      input logic [LANES-1:0] be, input logic [DW-1:0] d, input bit rr);
        cycle(1'b1, 1'b1, b, a, be, d, rr);
    endtask

    // One-cycle synchronous reset; everything pending is forgotten
    task automatic do_reset();
        hreset    = 1'b1;
        req_valid = 1'b0;
        req_write = 1'b0;
        rsp_ready = 1'b0;
        @(posedge hclk);
        edges++;
        rsp_q.delete();
        mem_model.delete();
        corrupt.delete();
        run_model = 1'b0;
        init_cnt  = 0;
        @(negedge hclk);
        hreset = 1'b0;
        #1;
        check("rst_req_ready", req_ready, 1'b0);
        check("rst_rsp_valid", rsp_valid, 1'b0);
        check("rst_rsp_rdata", rsp_rdata, '0);
        check("rst_rsp_err", rsp_err, 1'b0);
        check("rst_init_done", init_done, 1'b0);
    endtask

    task automatic random_traffic(input int n);
        bit                v;
        bit                w;
        bit                rr;
        logic [BANK_W-1:0] b;
        logic [ADDR_W-1:0] a;
        logic [LANES-1:0]  be;
        logic [DW-1:0]     d;
        for (int i = 0; i < n; i++) begin
            v  = ($urandom_range(0, 3) != 0);
            w  = ($urandom_range(0, 1) != 0);
            rr = ($urandom_range(0, 3) != 0);
            b  = BANK_W'($urandom_range(0, 3));
            a  = ADDR_W'($urandom_range(0, 15));
            be = LANES'($urandom_range(0, 15));
            d  = $urandom;
            cycle(v, w, b, a, be, d, rr);
        end
    endtask

    initial begin
        do_reset();
        idle(DEPTH + 2, 1'b1);

        // Top address of bank 1 reads back zero after the fill
        rd(2'd1, 13'h1FFF, 1'b1);
        idle(4, 1'b1);

        // Partial-lane write over a full word, then back-to-back reads
        wr(2'd0, 13'h010, 4'hF, 32'h11223344, 1'b1);
        wr(2'd0, 13'h010, 4'b0011, 32'hAABBCCDD, 1'b1);
        rd(2'd0, 13'h010, 1'b1);
        rd(2'd1, 13'h010, 1'b1);
        wr(2'd1, 13'h011, 4'b0000, 32'hFFFFFFFF, 1'b1);
        rd(2'd1, 13'h011, 1'b1);
        rd(2'd3, 13'h010, 1'b1);
        wr(2'd3, 13'h010, 4'hF, 32'hDEADBEEF, 1'b1);
        rd(2'd0, 13'h010, 1'b1);
        idle(5, 1'b1);

        // Backpressure: only two reads get in, writes still pass
        for (int i = 0; i < 5; i++) rd(2'd0, ADDR_W'(16 + i), 1'b0);
        wr(2'd1, 13'h020, 4'hF, 32'hCAFEF00D, 1'b0);
        rd(2'd1, 13'h020, 1'b0);
        idle(3, 1'b0);
        for (int i = 0; i < 6; i++) rd(2'd1, 13'h020, 1'b1);
        idle(5, 1'b1);

        random_traffic(3000);
        idle(5, 1'b1);

        // Reset with two responses pending, then again in the middle of INIT
        wr(2'd0, 13'h005, 4'hF, 32'h55AA55AA, 1'b0);
        rd(2'd0, 13'h005, 1'b0);
        rd(2'd0, 13'h005, 1'b0);
        idle(3, 1'b0);
        do_reset();
        idle(100, 1'b1);
        do_reset();
        idle(DEPTH + 2, 1'b1);
        rd(2'd0, 13'h005, 1'b1);
        rd(2'd0, 13'h010, 1'b1);
        idle(4, 1'b1);

`ifdef SRAM_BANK_ARRAY_PARITY_EN
        // A flipped stored parity bit in bank 0 lane 2 flags the response
        wr(2'd0, 13'h030, 4'hF, 32'h12345678, 1'b1);
        idle(1, 1'b1);
        dut.g_bank[0].g_lane[2].u_mem.mem[13'h030][8] = ~dut.g_bank[0].g_lane[2].u_mem.mem[13'h030][8];
        corrupt[key(0, 'h30)] = 1'b1;
        rd(2'd0, 13'h030, 1'b1);
        rd(2'd1, 13'h030, 1'b1);
        idle(4, 1'b1);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
